// File: rtl/freq_shift_nco.sv
// Complex carrier wipe-off: multiplies I/Q samples by exp(-j*phase) from an NCO.
// Pipeline: S1 samples + LUT, S2 full-width mix, S3 round/saturate + saturation count.
module freq_shift_nco #(
  parameter int IN_WIDTH    = 3,
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR    = 6,
  parameter int LUT_WIDTH   = 3,
  parameter int SHIFT       = 1,
  parameter int OUT_WIDTH   = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [PHASE_WIDTH-1:0] code,
  input  logic                          code_load,
  input  logic                          phase_clr,
  input  logic                          in_valid,
  input  logic signed [IN_WIDTH-1:0]    in_i,
  input  logic signed [IN_WIDTH-1:0]    in_q,
  output logic                          out_valid,
  output logic signed [OUT_WIDTH-1:0]   out_i,
  output logic signed [OUT_WIDTH-1:0]   out_q,
  input  logic                          sat_clr,
  output logic [CNT_WIDTH-1:0]          sat_cnt
);

  localparam int         F     = IN_WIDTH + LUT_WIDTH + 1;
  localparam int         LUT_N = 2 ** LUT_ADDR;
  localparam real        AMP   = real'(2 ** (LUT_WIDTH - 1) - 1);
  localparam logic [F:0] RND   = (F+1)'((2 ** SHIFT) / 2);
  localparam logic [F:0] MAXO  = (F+1)'(2 ** (OUT_WIDTH - 1) - 1);

  logic signed [LUT_WIDTH-1:0] cos_lut [LUT_N];
  logic signed [LUT_WIDTH-1:0] sin_lut [LUT_N];

  // Half-step offset keeps every entry away from a zero crossing.
  for (genvar a = 0; a < LUT_N; a++) begin : g_lut
    localparam real ANG = 2.0 * 3.141592653589793 * (real'(a) + 0.5) / real'(LUT_N);
    localparam real CR  = AMP * $cos(ANG);
    localparam real SR  = AMP * $sin(ANG);
    localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(-CR + 0.5);
    localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(-SR + 0.5);
    assign cos_lut[a] = LUT_WIDTH'(CI);
    assign sin_lut[a] = LUT_WIDTH'(SI);
  end

  logic [PHASE_WIDTH-1:0] code_q, phase_q, phase_use, phase_d;
  logic [LUT_ADDR-1:0]    addr;

  assign phase_use = phase_clr ? '0 : phase_q;
  assign addr      = phase_use[PHASE_WIDTH-1 -: LUT_ADDR];

  always_comb begin
    phase_d = phase_q;
    if (in_valid)       phase_d = phase_use + code_q;
    else if (phase_clr) phase_d = '0;
  end

  logic                        v1_q, v2_q;
  logic signed [IN_WIDTH-1:0]  i1_q, q1_q;
  logic signed [LUT_WIDTH-1:0] c1_q, s1_q;
  logic signed [F-1:0]         i1_x, q1_x, c1_x, s1_x;
  logic signed [F-1:0]         if_d, qf_d, if_q, qf_q;

  assign i1_x = {{(F-IN_WIDTH){i1_q[IN_WIDTH-1]}}, i1_q};
  assign q1_x = {{(F-IN_WIDTH){q1_q[IN_WIDTH-1]}}, q1_q};
  assign c1_x = {{(F-LUT_WIDTH){c1_q[LUT_WIDTH-1]}}, c1_q};
  assign s1_x = {{(F-LUT_WIDTH){s1_q[LUT_WIDTH-1]}}, s1_q};
  assign if_d = i1_x * c1_x + q1_x * s1_x;
  assign qf_d = q1_x * c1_x - i1_x * s1_x;

  // Returns {saturated, value}: sign-magnitude rounding then symmetric clip.
  function automatic logic [OUT_WIDTH:0] scale_sat(input logic signed [F-1:0] x);
    logic [F:0]           mag;
    logic                 sat;
    logic [OUT_WIDTH-1:0] res;
    mag = x[F-1] ? -{x[F-1], x} : {x[F-1], x};
    mag = (mag + RND) >> SHIFT;
    sat = (mag > MAXO);
    if (sat) mag = MAXO;
    res = mag[OUT_WIDTH-1:0];
    if (x[F-1]) res = -res;
    return {sat, res};
  endfunction

  logic [OUT_WIDTH:0]          ri, rq;
  logic                        sat_inc;
  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_i_q, out_q_q;
  logic [CNT_WIDTH-1:0]        sat_cnt_q;

  assign ri      = scale_sat(if_q);
  assign rq      = scale_sat(qf_q);
  assign sat_inc = v2_q & (ri[OUT_WIDTH] | rq[OUT_WIDTH]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q      <= '0;
      phase_q     <= '0;
      v1_q        <= 1'b0;
      i1_q        <= '0;
      q1_q        <= '0;
      c1_q        <= '0;
      s1_q        <= '0;
      v2_q        <= 1'b0;
      if_q        <= '0;
      qf_q        <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      sat_cnt_q   <= '0;
    end else begin
      if (code_load) code_q <= code;
      phase_q <= phase_d;
      v1_q    <= in_valid;
      if (in_valid) begin
        i1_q <= in_i;
        q1_q <= in_q;
        c1_q <= cos_lut[addr];
        s1_q <= sin_lut[addr];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        if_q <= if_d;
        qf_q <= qf_d;
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_i_q <= ri[OUT_WIDTH-1:0];
        out_q_q <= rq[OUT_WIDTH-1:0];
      end
      if (sat_clr)                     sat_cnt_q <= '0;
      else if (sat_inc && ~&sat_cnt_q) sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_freq_shift_nco.sv
// Directed bench for freq_shift_nco at default parameters (A=3, 64-entry LUT, SHIFT=1).
// Expected outputs are hand-computed from the mixing equations; checks are immediate assertions.
module tb_freq_shift_nco;

  typedef int arr4_t[4];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic signed [31:0] code = '0;
  logic              code_load = 1'b0;
  logic              phase_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [2:0] in_i = '0;
  logic signed [2:0] in_q = '0;
  logic              out_valid;
  logic signed [2:0] out_i;
  logic signed [2:0] out_q;
  logic              sat_clr = 1'b0;
  logic [15:0]       sat_cnt;

  int errors = 0;
  int checks = 0;
  int last_i = 0;
  int last_q = 0;

  freq_shift_nco dut (
    .clk       (clk),
    .reset     (reset),
    .code      (code),
    .code_load (code_load),
    .phase_clr (phase_clr),
    .in_valid  (in_valid),
    .in_i      (in_i),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_i     (out_i),
    .out_q     (out_q),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_code(input logic signed [31:0] c);
    code      = c;
    code_load = 1'b1;
    tick();
    code_load = 1'b0;
  endtask

  // Drives n samples, one every gap+1 cycles; output k is expected 3 cycles after its strobe.
  task automatic run(input string tag, input int n, input int gap,
                     input arr4_t ii, input arr4_t qq, input arr4_t ei, input arr4_t eq,
                     input logic [3:0] clr, input int exp_sat);
    int last_slot;
    last_slot = (n - 1) * (gap + 1);
    for (int cyc = 0; cyc <= last_slot + 3; cyc++) begin
      bit slot;
      bit expv;
      int k;
      int oc;
      k    = cyc / (gap + 1);
      slot = (cyc % (gap + 1) == 0) && (k < n);
      in_valid  = slot;
      phase_clr = slot ? clr[k] : 1'b0;
      in_i      = slot ? 3'(ii[k]) : 3'sd0;
      in_q      = slot ? 3'(qq[k]) : 3'sd0;
      tick();
      oc   = cyc - 2;
      expv = (oc >= 0) && (oc % (gap + 1) == 0) && (oc / (gap + 1) < n);
      if (expv) begin
        last_i = ei[oc / (gap + 1)];
        last_q = eq[oc / (gap + 1)];
      end
      chk({tag, "_valid"}, out_valid, expv);
      chk({tag, "_i"}, out_i, last_i);
      chk({tag, "_q"}, out_q, last_q);
    end
    in_valid  = 1'b0;
    phase_clr = 1'b0;
    chk({tag, "_satcnt"}, sat_cnt, exp_sat);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_i", out_i, 0);
    chk("rst_q", out_q, 0);
    chk("rst_satcnt", sat_cnt, 0);
    reset = 1'b0;
    tick();

    // code=0, address 0: cos=3, sin=0 -> (1,0) gives I_f=3 -> 2
    run("dc", 4, 0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, '{2, 2, 2, 2}, '{0, 0, 0, 0}, 4'b0000, 0);

    // Quarter-turn steps: addresses 0,16,32,48
    load_code(32'sh4000_0000);
    run("quarter", 4, 0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, '{2, 0, -2, 0}, '{0, -2, 0, 2}, 4'b0001, 0);

    // Gapped strobes: phase moves only on accepted samples
    run("gapped", 3, 2, '{1, 1, 1, 0}, '{0, 0, 0, 0}, '{2, 0, -2, 0}, '{0, -2, 0, 0}, 4'b0001, 0);

    // Running stream starts at address 48; third sample clears phase -> addr 0 then 16
    run("midclr", 4, 0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, '{0, 2, 2, 0}, '{2, 0, 0, -2}, 4'b0100, 0);

    // Saturation: (3,3) -> 9 -> 5 clipped to 3; (-4,-4) -> -12 -> -6 clipped to -3
    load_code(32'sh0);
    phase_clr = 1'b1;
    in_valid = 1'b1; in_i = 3'sd3;  in_q = 3'sd3;  tick();
    phase_clr = 1'b0;
    in_i = -3'sd4; in_q = -3'sd4; tick();
    in_i = 3'sd3;  in_q = 3'sd3;  tick();
    in_valid = 1'b0;
    chk("sat1_valid", out_valid, 1);
    chk("sat1_i", out_i, 3);
    chk("sat1_q", out_q, 3);
    chk("sat1_cnt", sat_cnt, 1);
    tick();
    chk("sat2_i", out_i, -3);
    chk("sat2_q", out_q, -3);
    chk("sat2_cnt", sat_cnt, 2);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat3_valid", out_valid, 1);
    chk("sat3_i", out_i, 3);
    chk("sat3_cnt_clr_wins", sat_cnt, 0);
    tick();
    chk("sat_idle_valid", out_valid, 0);
    chk("sat_idle_cnt", sat_cnt, 0);
    last_i = 3;
    last_q = 3;

    // Reset with two samples in flight
    load_code(32'sh4000_0000);
    in_valid = 1'b1; in_i = 3'sd1; in_q = 3'sd0; tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst_async_valid", out_valid, 0);
    chk("mrst_async_i", out_i, 0);
    tick();
    chk("mrst_hold_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mrst_flush_valid", out_valid, 0);
    end
    chk("mrst_satcnt", sat_cnt, 0);
    last_i = 0;
    last_q = 0;
    // code_reg cleared by reset: both samples stay at address 0
    run("post_rst", 2, 0, '{1, 1, 0, 0}, '{0, 0, 0, 0}, '{2, 2, 0, 0}, '{0, 0, 0, 0}, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
